// File: rtl/mmc_cmd_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | mmc_cmd_ctrl_pkg: shared codes and helpers for the MMC command    |
// | sequencer.                                  Revision: 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

package mmc_cmd_ctrl_pkg;

  localparam logic [1:0] C_RESP_NONE      = 2'd0;
  localparam logic [1:0] C_RESP_R48       = 2'd1;
  localparam logic [1:0] C_RESP_R48_NOCRC = 2'd2;
  localparam logic [1:0] C_RESP_R136      = 2'd3;

  localparam logic [2:0] C_ST_IDLE = 3'd0;
  localparam logic [2:0] C_ST_TX   = 3'd1;
  localparam logic [2:0] C_ST_WAIT = 3'd2;
  localparam logic [2:0] C_ST_RX   = 3'd3;
  localparam logic [2:0] C_ST_GAP  = 3'd4;

  localparam int C_STS_TIMEOUT   = 0;
  localparam int C_STS_CRC_ERR   = 1;
  localparam int C_STS_INDEX_ERR = 2;
  localparam int C_STS_ABORTED   = 3;

  localparam int C_CNT_W = 8;

  // Start bit, transmission bit, index, argument, CRC7 field (filled by serialiser), end bit.
  function automatic logic [47:0] build_frame(input logic [5:0] index, input logic [31:0] arg);
    return {2'b01, index, arg, 7'h00, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmc_cmd_ctrl_bit_timer.sv
// +------------------------------------------------------------------+
// | mmc_cmd_ctrl_bit_timer: bitclk rising-edge detect plus a          |
// | clearable saturating tick counter.          Revision: 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module mmc_cmd_ctrl_bit_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bitclk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             r_bitclk_q;
  logic [CNT_W-1:0] r_cnt;

  assign tick_o = bitclk_i & ~r_bitclk_q;
  assign cnt_o  = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bitclk_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_bitclk_q <= bitclk_i;
      if (clr_i) begin
        r_cnt <= '0;
      end else if (en_i && tick_o && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmc_cmd_ctrl.sv
// +------------------------------------------------------------------+
// | mmc_cmd_ctrl: MMC/SD command-line sequencer with NCR timeout and  |
// | NCC gap enforcement.                        Revision: 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module mmc_cmd_ctrl
  import mmc_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64,
  parameter int GAP_BITS     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         bitclk_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [5:0]   req_index_i,
  input  logic [31:0]  req_arg_i,
  input  logic [1:0]   req_resp_i,
  input  logic         abort_i,
  output logic         ser_start_o,
  output logic         ser_abort_o,
  output logic [47:0]  ser_data_o,
  input  logic         ser_complete_i,
  output logic         rx_start_o,
  output logic         rx_abort_o,
  output logic         rx_long_o,
  input  logic         rx_active_i,
  input  logic         rx_complete_i,
  input  logic         rx_crc_err_i,
  input  logic [135:0] rx_data_i,
  output logic         done_o,
  output logic [135:0] resp_o,
  output logic [3:0]   sts_o
);

  localparam logic [C_CNT_W-1:0] C_TO_LAST  = C_CNT_W'(TIMEOUT_BITS - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST = C_CNT_W'(GAP_BITS - 1);

  logic [2:0]   r_state;
  logic [5:0]   r_index;
  logic [1:0]   r_resp_type;
  logic [47:0]  r_ser_data;
  logic         r_ser_start;
  logic         r_ser_abort;
  logic         r_rx_start;
  logic         r_rx_abort;
  logic         r_rx_long;
  logic         r_done;
  logic [135:0] r_resp;
  logic [3:0]   r_sts;

  logic               w_accept;
  logic               w_abort;
  logic               w_to_tick;
  logic [C_CNT_W-1:0] w_to_cnt;
  logic               w_to_hit;
  logic               w_gap_tick;
  logic [C_CNT_W-1:0] w_gap_cnt;
  logic               w_gap_done;
  logic               w_capture;

  // Counters sit cleared outside their own state, so each starts from zero on entry.
  mmc_cmd_ctrl_bit_timer #(.CNT_W(C_CNT_W)) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .bitclk_i (bitclk_i),
    .clr_i    (r_state != C_ST_WAIT),
    .en_i     (~rx_active_i),
    .tick_o   (w_to_tick),
    .cnt_o    (w_to_cnt)
  );

  mmc_cmd_ctrl_bit_timer #(.CNT_W(C_CNT_W)) u_gap (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .bitclk_i (bitclk_i),
    .clr_i    (r_state != C_ST_GAP),
    .en_i     (1'b1),
    .tick_o   (w_gap_tick),
    .cnt_o    (w_gap_cnt)
  );

  assign req_ready_o = (r_state == C_ST_IDLE) & ~abort_i;
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_abort     = abort_i & ((r_state == C_ST_TX) | (r_state == C_ST_WAIT) | (r_state == C_ST_RX));
  assign w_to_hit    = (r_state == C_ST_WAIT) & ~rx_active_i & w_to_tick & (w_to_cnt == C_TO_LAST);
  assign w_gap_done  = (r_state == C_ST_GAP) & w_gap_tick & (w_gap_cnt == C_GAP_LAST);
  // A response finishing on the timeout edge still counts as a response.
  assign w_capture   = rx_complete_i & ((r_state == C_ST_RX) | w_to_hit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= C_ST_IDLE;
      r_index     <= '0;
      r_resp_type <= C_RESP_NONE;
      r_ser_data  <= '0;
      r_ser_start <= 1'b0;
      r_ser_abort <= 1'b0;
      r_rx_start  <= 1'b0;
      r_rx_abort  <= 1'b0;
      r_rx_long   <= 1'b0;
      r_done      <= 1'b0;
      r_resp      <= '0;
      r_sts       <= '0;
    end else begin
      r_ser_start <= 1'b0;
      r_ser_abort <= 1'b0;
      r_rx_start  <= 1'b0;
      r_rx_abort  <= 1'b0;
      r_done      <= 1'b0;
      if (w_abort) begin
        r_ser_abort          <= 1'b1;
        r_rx_abort           <= 1'b1;
        r_sts[C_STS_ABORTED] <= 1'b1;
        r_done               <= 1'b1;
        r_state              <= C_ST_GAP;
      end else if (w_capture) begin
        r_resp                 <= (r_resp_type == C_RESP_R136) ? rx_data_i : {88'd0, rx_data_i[47:0]};
        r_sts[C_STS_CRC_ERR]   <= rx_crc_err_i & (r_resp_type != C_RESP_R48_NOCRC);
        r_sts[C_STS_INDEX_ERR] <= (r_resp_type == C_RESP_R48) & (rx_data_i[45:40] != r_index);
        r_done                 <= 1'b1;
        r_state                <= C_ST_GAP;
      end else begin
        case (r_state)
          C_ST_IDLE: begin
            if (w_accept) begin
              r_index     <= req_index_i;
              r_resp_type <= req_resp_i;
              r_ser_data  <= build_frame(req_index_i, req_arg_i);
              r_sts       <= '0;
              r_ser_start <= 1'b1;
              r_state     <= C_ST_TX;
            end
          end
          C_ST_TX: begin
            if (ser_complete_i) begin
              if (r_resp_type == C_RESP_NONE) begin
                r_done  <= 1'b1;
                r_state <= C_ST_GAP;
              end else begin
                r_rx_start <= 1'b1;
                r_rx_long  <= (r_resp_type == C_RESP_R136);
                r_state    <= C_ST_WAIT;
              end
            end
          end
          C_ST_WAIT: begin
            if (w_to_hit) begin
              r_sts[C_STS_TIMEOUT] <= 1'b1;
              r_rx_abort           <= 1'b1;
              r_done               <= 1'b1;
              r_state              <= C_ST_GAP;
            end else if (rx_active_i) begin
              r_state <= C_ST_RX;
            end
          end
          C_ST_RX: begin
            r_state <= C_ST_RX;
          end
          C_ST_GAP: begin
            if (w_gap_done) begin
              r_state <= C_ST_IDLE;
            end
          end
          default: begin
            r_state <= C_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ser_start_o = r_ser_start;
  assign ser_abort_o = r_ser_abort;
  assign ser_data_o  = r_ser_data;
  assign rx_start_o  = r_rx_start;
  assign rx_abort_o  = r_rx_abort;
  assign rx_long_o   = r_rx_long;
  assign done_o      = r_done;
  assign resp_o      = r_resp;
  assign sts_o       = r_sts;

endmodule

`default_nettype wire

// File: tb/tb_mmc_cmd_ctrl.sv
// +------------------------------------------------------------------+
// | tb_mmc_cmd_ctrl: directed self-checking bench for mmc_cmd_ctrl.   |
// |                                             Revision: 1.0        |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mmc_cmd_ctrl;

  localparam int TIMEOUT_BITS = 64;
  localparam int GAP_BITS     = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         bitclk_i = 1'b0;
  logic         bitclk_prev = 1'b0;
  logic         div = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [5:0]   req_index_i = '0;
  logic [31:0]  req_arg_i = '0;
  logic [1:0]   req_resp_i = '0;
  logic         abort_i = 1'b0;
  logic         ser_start_o;
  logic         ser_abort_o;
  logic [47:0]  ser_data_o;
  logic         ser_complete_i = 1'b0;
  logic         rx_start_o;
  logic         rx_abort_o;
  logic         rx_long_o;
  logic         rx_active_i = 1'b0;
  logic         rx_complete_i = 1'b0;
  logic         rx_crc_err_i = 1'b0;
  logic [135:0] rx_data_i = '0;
  logic         done_o;
  logic [135:0] resp_o;
  logic [3:0]   sts_o;

  mmc_cmd_ctrl #(.TIMEOUT_BITS(TIMEOUT_BITS), .GAP_BITS(GAP_BITS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .bitclk_i       (bitclk_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_index_i    (req_index_i),
    .req_arg_i      (req_arg_i),
    .req_resp_i     (req_resp_i),
    .abort_i        (abort_i),
    .ser_start_o    (ser_start_o),
    .ser_abort_o    (ser_abort_o),
    .ser_data_o     (ser_data_o),
    .ser_complete_i (ser_complete_i),
    .rx_start_o     (rx_start_o),
    .rx_abort_o     (rx_abort_o),
    .rx_long_o      (rx_long_o),
    .rx_active_i    (rx_active_i),
    .rx_complete_i  (rx_complete_i),
    .rx_crc_err_i   (rx_crc_err_i),
    .rx_data_i      (rx_data_i),
    .done_o         (done_o),
    .resp_o         (resp_o),
    .sts_o          (sts_o)
  );

  always #5 clk_i = ~clk_i;

  // Card clock: one rising edge every four core cycles.
  always @(posedge clk_i) begin
    div         <= ~div;
    bitclk_prev <= bitclk_i;
    if (div) bitclk_i <= ~bitclk_i;
  end

  logic tb_tick;
  assign tb_tick = bitclk_i & ~bitclk_prev;

  int tick_total = 0;
  always @(posedge clk_i) if (tb_tick) tick_total <= tick_total + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [3:0]   sts;
    logic [135:0] resp;
  } exp_t;

  exp_t         sb[$];
  logic [135:0] m_last_resp = '0;
  int           n_exp_done = 0;
  int           n_done = 0;
  int           done_tick = 0;
  int           acc_tick = 0;
  bit           chk_en = 1'b0;

  // Transaction-level model: busy from accept to done, then GAP_BITS card ticks of idle.
  bit m_busy   = 1'b0;
  int gap_left = 0;
  bit acc_prev = 1'b0;

  always @(negedge clk_i) begin
    bit   exp_ready;
    exp_t e;
    if (!rst_ni) begin
      m_busy   = 1'b0;
      gap_left = 0;
      acc_prev = 1'b0;
      sb.delete();
    end else if (chk_en) begin
      exp_ready = !m_busy && (gap_left == 0) && !abort_i;
      chk("req_ready", 136'(req_ready_o), 136'(exp_ready));
      chk("ser_start", 136'(ser_start_o), 136'(acc_prev));
      if (done_o) begin
        n_done++;
        done_tick = tick_total;
        if (sb.size() == 0) begin
          chk("done_expected", 136'(sb.size() != 0), 136'(1));
        end else begin
          e = sb.pop_front();
          chk("sts", 136'(sts_o), 136'(e.sts));
          chk("resp", resp_o, e.resp);
        end
        m_busy   = 1'b0;
        gap_left = GAP_BITS;
      end
      if (gap_left > 0 && tb_tick) gap_left--;
      acc_prev = req_valid_i && exp_ready;
      if (acc_prev) m_busy = 1'b1;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},     136'(req_ready_o), 136'(1));
    chk({tag, "_ser_start"}, 136'(ser_start_o), 136'(0));
    chk({tag, "_ser_abort"}, 136'(ser_abort_o), 136'(0));
    chk({tag, "_ser_data"},  136'(ser_data_o),  136'(0));
    chk({tag, "_rx_start"},  136'(rx_start_o),  136'(0));
    chk({tag, "_rx_abort"},  136'(rx_abort_o),  136'(0));
    chk({tag, "_rx_long"},   136'(rx_long_o),   136'(0));
    chk({tag, "_done"},      136'(done_o),      136'(0));
    chk({tag, "_resp"},      resp_o,            136'(0));
    chk({tag, "_sts"},       136'(sts_o),       136'(0));
  endtask

  // mode: 0 normal response, 1 no start bit, 2 abort during TX, 3 reset during RX
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int mode, input bit crc, input logic [135:0] rdata);
    exp_t e;
    int   n;
    int   t;
    int   nab;
    bit   seen;
    e.resp = m_last_resp;
    if (mode == 1)      e.sts = 4'b0001;
    else if (mode == 2) e.sts = 4'b1000;
    else if (rt == 2'd0) e.sts = 4'b0000;
    else begin
      e.sts  = {1'b0, (rt == 2'd1) && (rdata[45:40] != idx), crc && (rt != 2'd2), 1'b0};
      e.resp = (rt == 2'd3) ? rdata : {88'd0, rdata[47:0]};
    end
    if (mode != 3) begin
      sb.push_back(e);
      n_exp_done++;
      if (mode == 0 && rt != 2'd0) m_last_resp = e.resp;
    end

    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_index_i = idx; req_arg_i = arg; req_resp_i = rt;
    seen = 1'b0;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk_i);
      if (req_ready_o) begin seen = 1'b1; break; end
    end
    acc_tick = tick_total;
    if (!seen) begin
      chk("accept_seen", 136'(seen), 136'(1));
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ser_data", 136'(ser_data_o), 136'({2'b01, idx, arg, 7'h00, 1'b1}));
    repeat (2) @(posedge clk_i);

    if (mode == 2) begin
      #1 abort_i = 1'b1;
      @(posedge clk_i); #1 abort_i = 1'b0;
      @(negedge clk_i);
      chk("abort_ser_abort", 136'(ser_abort_o), 136'(1));
      chk("abort_rx_abort",  136'(rx_abort_o),  136'(1));
      chk("abort_done",      136'(done_o),      136'(1));
      @(negedge clk_i);
      chk("abort_ser_abort_once", 136'(ser_abort_o), 136'(0));
      chk("abort_done_once",      136'(done_o),      136'(0));
      return;
    end

    #1 ser_complete_i = 1'b1;
    @(posedge clk_i); #1 ser_complete_i = 1'b0;
    @(negedge clk_i);
    if (rt == 2'd0) begin
      chk("none_done", 136'(done_o), 136'(1));
      return;
    end
    chk("rx_start", 136'(rx_start_o), 136'(1));
    chk("rx_long",  136'(rx_long_o),  136'(rt == 2'd3));

    if (mode == 1) begin
      t = 0; nab = 0; seen = 1'b0;
      for (n = 0; n < 1000; n++) begin
        if (done_o) begin seen = 1'b1; break; end
        if (rx_abort_o) nab++;
        if (tb_tick) t++;
        @(negedge clk_i);
      end
      chk("timeout_done_seen", 136'(seen), 136'(1));
      chk("timeout_ticks", 136'(t), 136'(TIMEOUT_BITS));
      chk("timeout_rx_abort", 136'(rx_abort_o), 136'(1));
      chk("timeout_rx_abort_early", 136'(nab), 136'(0));
      @(negedge clk_i);
      chk("timeout_rx_abort_once", 136'(rx_abort_o), 136'(0));
      return;
    end

    repeat (3) @(posedge clk_i);
    #1 rx_active_i = 1'b1;
    repeat (10) @(posedge clk_i);
    if (mode == 3) begin
      #1 rst_ni = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("midrx");
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1; rx_active_i = 1'b0;
      m_last_resp = '0;
      repeat (2) begin
        @(negedge clk_i);
        chk("post_reset_aborts", 136'({ser_abort_o, rx_abort_o, done_o}), 136'(0));
      end
      return;
    end
    #1 rx_complete_i = 1'b1; rx_data_i = rdata; rx_crc_err_i = crc;
    @(posedge clk_i); #1 rx_complete_i = 1'b0; rx_active_i = 1'b0; rx_crc_err_i = 1'b0;
    @(negedge clk_i);
    chk("rx_done", 136'(done_o), 136'(1));
  endtask

  function automatic logic [135:0] r48(input logic [5:0] idx, input logic [31:0] status);
    logic [87:0] junk;
    junk = 88'hA5A5_A5A5_A5A5_A5A5_A5A5_A5;
    return {junk, 2'b00, idx, status, 7'h2A, 1'b1};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [135:0] d;
    logic [135:0] long_pat;
    long_pat = {8'h3F, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211};

    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    chk_en = 1'b1;

    // CMD0, no response
    run_cmd(6'd0, 32'h0, 2'd0, 0, 1'b0, '0);
    chk("t1_frame", 136'(ser_data_o), 136'(48'h4000_0000_0001));
    chk("t1_sts", 136'(sts_o), 136'(4'b0000));

    // CMD17 R48, echoed index, immediately after the previous done
    d = r48(6'd17, 32'h0000_0900);
    run_cmd(6'd17, 32'h0000_1000, 2'd1, 0, 1'b0, d);
    chk("t1_gap_ticks", 136'(acc_tick - done_tick), 136'(GAP_BITS));
    chk("t2_frame", 136'(ser_data_o), 136'(48'h51_0000_1000_01));
    chk("t2_resp_index", 136'(resp_o[45:40]), 136'(6'd17));
    chk("t2_resp_upper_zero", 136'(resp_o[135:48]), 136'(0));
    chk("t2_sts", 136'(sts_o), 136'(4'b0000));

    // Index mismatch, R3 CRC ignored, R48 CRC error
    d = r48(6'd16, 32'h0000_0900);
    run_cmd(6'd17, 32'h0000_2000, 2'd1, 0, 1'b0, d);
    chk("t3_index_err", 136'(sts_o), 136'(4'b0100));
    d = r48(6'h3F, 32'h80FF_8000);
    run_cmd(6'd41, 32'h40FF_8000, 2'd2, 0, 1'b1, d);
    chk("t3_r3_crc_ignored", 136'(sts_o), 136'(4'b0000));
    d = r48(6'd13, 32'h0000_0000);
    run_cmd(6'd13, 32'h0001_0000, 2'd1, 0, 1'b1, d);
    chk("t3_crc_err", 136'(sts_o), 136'(4'b0010));

    // No start bit
    run_cmd(6'd13, 32'h0001_0000, 2'd1, 1, 1'b0, '0);
    chk("t4_timeout_sts", 136'(sts_o), 136'(4'b0001));

    // CMD2 R136
    run_cmd(6'd2, 32'h0, 2'd3, 0, 1'b0, long_pat);
    chk("t6_long_resp", resp_o, long_pat);

    // Abort during TX
    run_cmd(6'd24, 32'h0000_0200, 2'd1, 2, 1'b0, '0);
    chk("t5_abort_sts", 136'(sts_o), 136'(4'b1000));

    // Reset during RX
    d = r48(6'd17, 32'h0);
    run_cmd(6'd17, 32'h0000_3000, 2'd1, 3, 1'b0, d);

    // Back-to-back requests after reset
    run_cmd(6'd0, 32'h0, 2'd0, 0, 1'b0, '0);
    run_cmd(6'd0, 32'h0000_1234, 2'd0, 0, 1'b0, '0);
    chk("b2b_gap_ticks", 136'(acc_tick - done_tick), 136'(GAP_BITS));
    chk("b2b_frame", 136'(ser_data_o), 136'(48'h4000_0012_3401));

    repeat (40) @(negedge clk_i);
    chk("done_count", 136'(n_done), 136'(n_exp_done));
    chk("scoreboard_empty", 136'(sb.size()), 136'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
